// File: rtl/inst_fetch_buffer.sv
// Fetch-to-decode decoupling ring buffer: records accepted fetch requests in order,
// pairs in-order icache responses with them, and drops responses owed to flushed requests.
module inst_fetch_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_pc,
  input  logic                  if_branch,
  input  logic [ADDR_WIDTH-1:0] if_branch_addr,
  input  logic [3:0]            if_except_type,
  output logic                  if_ready,
  input  logic                  inst_addr_ok,
  input  logic                  inst_data_ok,
  input  logic [ADDR_WIDTH-1:0] inst_rdata,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [ADDR_WIDTH-1:0] id_inst,
  output logic                  id_branch,
  output logic [ADDR_WIDTH-1:0] id_branch_addr,
  output logic [3:0]            id_except_type
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic [DEPTH-1:0]      valid_q, valid_d, done_q, done_d, br_q, br_d;
  logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_d [DEPTH];
  logic [ADDR_WIDTH-1:0] inst_q [DEPTH];
  logic [ADDR_WIDTH-1:0] inst_d [DEPTH];
  logic [ADDR_WIDTH-1:0] bra_q [DEPTH];
  logic [ADDR_WIDTH-1:0] bra_d [DEPTH];
  logic [3:0]            exc_q [DEPTH];
  logic [3:0]            exc_d [DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DW-1:0]         discard_q, discard_d;

  logic [CW-1:0] pending;
  logic [OW-1:0] outstanding, disc_sum;
  logic [PW-1:0] dptr, idx;
  logic          found, exc, push, pop;

  // dptr: oldest valid entry still waiting for its instruction, searched from head
  always_comb begin
    pending = '0;
    dptr    = head_q;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !done_q[i]) pending = pending + CW'(1);
      idx = head_q + PW'(i);
      if (!found && valid_q[idx] && !done_q[idx]) begin
        dptr  = idx;
        found = 1'b1;
      end
    end
  end

  assign exc         = |if_except_type;
  assign outstanding = OW'(pending) + OW'(discard_q);
  assign if_ready    = !rst && !flush && (count_q < CW'(DEPTH)) &&
                       (exc || (inst_addr_ok && (outstanding < OW'(DEPTH))));
  assign push        = if_valid && if_ready;

  assign id_valid       = valid_q[head_q] && done_q[head_q];
  assign id_pc          = pc_q[head_q];
  assign id_inst        = inst_q[head_q];
  assign id_branch      = br_q[head_q];
  assign id_branch_addr = bra_q[head_q];
  assign id_except_type = exc_q[head_q];
  assign pop            = id_valid && id_ready;

  always_comb begin
    valid_d   = valid_q;
    done_d    = done_q;
    br_d      = br_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    bra_d     = bra_q;
    exc_d     = exc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    discard_d = discard_q;
    disc_sum  = OW'(discard_q) + OW'(pending);
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      br_d    = '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_d[i]   = '0;
        inst_d[i] = '0;
        bra_d[i]  = '0;
        exc_d[i]  = '0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      // a response arriving with the flush is the first of the owed ones
      if (inst_data_ok && (disc_sum != '0)) disc_sum = disc_sum - OW'(1);
      discard_d = DW'(disc_sum);
    end else begin
      if (inst_data_ok) begin
        if (discard_q != '0) begin
          discard_d = discard_q - DW'(1);
        end else if (pending != '0) begin
          inst_d[dptr] = inst_rdata;
          done_d[dptr] = 1'b1;
        end
      end
      if (push) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = exc;
        pc_d[tail_q]    = if_pc;
        inst_d[tail_q]  = '0;
        br_d[tail_q]    = if_branch;
        bra_d[tail_q]   = if_branch_addr;
        exc_d[tail_q]   = if_except_type;
        tail_d          = tail_q + PW'(1);
      end
      if (pop) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        pc_d[head_q]    = '0;
        inst_d[head_q]  = '0;
        br_d[head_q]    = 1'b0;
        bra_d[head_q]   = '0;
        exc_d[head_q]   = '0;
        head_d          = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      done_q    <= '0;
      br_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
        bra_q[i]  <= '0;
        exc_q[i]  <= '0;
      end
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      discard_q <= '0;
    end else begin
      valid_q   <= valid_d;
      done_q    <= done_d;
      br_q      <= br_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      bra_q     <= bra_d;
      exc_q     <= exc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer: inputs change and outputs are sampled just after negedge.
module tb_inst_fetch_buffer;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst, flush, if_valid, if_branch, if_ready;
  logic [AW-1:0] if_pc, if_branch_addr, inst_rdata;
  logic [3:0]    if_except_type;
  logic          inst_addr_ok, inst_data_ok, id_valid, id_ready, id_branch;
  logic [AW-1:0] id_pc, id_inst, id_branch_addr;
  logic [3:0]    id_except_type;

  int n_checks = 0;
  int n_errors = 0;

  inst_fetch_buffer #(.DEPTH(4), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_branch(if_branch),
    .if_branch_addr(if_branch_addr), .if_except_type(if_except_type),
    .if_ready(if_ready), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_branch(id_branch),
    .id_branch_addr(id_branch_addr), .id_except_type(id_except_type)
  );

  always #5 clk = ~clk;

  task automatic idle();
    flush = 0; if_valid = 0; if_pc = '0; if_branch = 0; if_branch_addr = '0;
    if_except_type = '0; inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;
  endtask

  // start a new cycle: advance to the next negedge with idle inputs
  task automatic next();
    @(negedge clk);
    idle();
  endtask

  task automatic req(input logic [AW-1:0] pc, input logic [3:0] et);
    if_valid = 1; if_pc = pc; if_except_type = et; inst_addr_ok = (et == 4'd0);
    if_branch = pc[2]; if_branch_addr = pc + 32'h40;
  endtask

  task automatic resp(input logic [AW-1:0] d);
    inst_data_ok = 1; inst_rdata = d;
  endtask

  task automatic test_reset();
    rst = 1; id_ready = 1;
    next(); req(32'h1c000000, 4'd0); #1;
    n_checks++; if (if_ready !== 1'b0) begin n_errors++; $display("FAIL reset_if_ready got %b exp 0", if_ready); end
    next(); req(32'h1c000000, 4'd0); #1;
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL reset_id_valid got %b exp 0", id_valid); end
    n_checks++; if ({id_pc, id_inst, id_branch_addr, id_branch, id_except_type} !== '0) begin
      n_errors++; $display("FAIL reset_id_fields got pc=%h inst=%h exp 0", id_pc, id_inst); end
    rst = 0; idle(); #1;
  endtask

  task automatic test_stream();
    logic [AW-1:0] ins [3];
    ins[0] = 32'hA0000001; ins[1] = 32'hA0000002; ins[2] = 32'hA0000003;
    id_ready = 1;
    for (int c = 0; c < 6; c++) begin
      next();
      if (c < 3) req(32'h1c000000 + 32'(4 * c), 4'd0);
      if (c >= 1 && c <= 3) resp(ins[c-1]);
      #1;
      if (c < 3) begin
        n_checks++; if (if_ready !== 1'b1) begin n_errors++; $display("FAIL stream_if_ready c%0d got %b exp 1", c, if_ready); end
      end
      if (c >= 2 && c <= 4) begin
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h1c000000 + 32'(4 * (c - 2)) || id_inst !== ins[c-2]) begin
          n_errors++; $display("FAIL stream_out c%0d got v=%b pc=%h inst=%h exp pc=%h inst=%h",
            c, id_valid, id_pc, id_inst, 32'h1c000000 + 32'(4 * (c - 2)), ins[c-2]); end
      end else begin
        n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL stream_idle c%0d got %b exp 0", c, id_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    id_ready = 0;
    for (int c = 0; c < 5; c++) begin
      next();
      req(32'h1c000200 + 32'(4 * c), 4'd0);
      if (c >= 1) resp(32'hB0000000 + 32'(c - 1));
      #1;
      if (c == 4) begin
        n_checks++; if (if_ready !== 1'b0) begin n_errors++; $display("FAIL bp_full got %b exp 0", if_ready); end
      end
    end
    next(); req(32'h1c000300, 4'd0); id_ready = 1; #1;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h1c000200 || id_inst !== 32'hB0000000) begin
      n_errors++; $display("FAIL bp_head got v=%b pc=%h inst=%h exp pc=1c000200 inst=b0000000", id_valid, id_pc, id_inst); end
    n_checks++; if (if_ready !== 1'b0) begin n_errors++; $display("FAIL bp_same_cycle got %b exp 0", if_ready); end
    next(); id_ready = 0; inst_addr_ok = 1; #1;
    n_checks++; if (if_ready !== 1'b1) begin n_errors++; $display("FAIL bp_freed got %b exp 1", if_ready); end
    id_ready = 1;
    for (int k = 1; k < 4; k++) begin
      if (k > 1) next();
      #1;
      n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h1c000200 + 32'(4 * k) || id_inst !== 32'hB0000000 + 32'(k)) begin
        n_errors++; $display("FAIL bp_drain%0d got v=%b pc=%h inst=%h", k, id_valid, id_pc, id_inst); end
    end
    next(); #1;
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL bp_empty got %b exp 0", id_valid); end
  endtask

  task automatic test_flush_pending();
    id_ready = 1;
    next(); req(32'h1c000300, 4'd0);
    next(); req(32'h1c000304, 4'd0);
    next(); flush = 1; #1;
    n_checks++; if (if_ready !== 1'b0) begin n_errors++; $display("FAIL fp_flush_ready got %b exp 0", if_ready); end
    next(); req(32'h1c000100, 4'd0); resp(32'hDEAD0000); #1;
    n_checks++; if (dut.discard_q !== 3'd2) begin n_errors++; $display("FAIL fp_discard got %0d exp 2", dut.discard_q); end
    n_checks++; if (if_ready !== 1'b1) begin n_errors++; $display("FAIL fp_new_req got %b exp 1", if_ready); end
    next(); resp(32'hDEAD0001); #1;
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL fp_drop1 got %b exp 0", id_valid); end
    next(); resp(32'hC0000100); #1;
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL fp_drop2 got %b exp 0", id_valid); end
    next(); #1;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h1c000100 || id_inst !== 32'hC0000100) begin
      n_errors++; $display("FAIL fp_out got v=%b pc=%h inst=%h exp pc=1c000100 inst=c0000100", id_valid, id_pc, id_inst); end
    next(); #1;
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL fp_only_one got %b exp 0", id_valid); end
  endtask

  task automatic test_flush_data();
    id_ready = 1;
    for (int c = 0; c < 3; c++) begin next(); req(32'h1c000380 + 32'(4 * c), 4'd0); end
    next(); flush = 1; resp(32'hDEAD0010);
    next(); req(32'h1c000400, 4'd0); resp(32'hDEAD0011); #1;
    n_checks++; if (dut.discard_q !== 3'd2) begin n_errors++; $display("FAIL fd_discard got %0d exp 2", dut.discard_q); end
    next(); resp(32'hDEAD0012);
    next(); resp(32'hC0000400); #1;
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL fd_dropped got %b exp 0", id_valid); end
    next(); #1;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h1c000400 || id_inst !== 32'hC0000400) begin
      n_errors++; $display("FAIL fd_out got v=%b pc=%h inst=%h exp pc=1c000400 inst=c0000400", id_valid, id_pc, id_inst); end
    next(); #1;
  endtask

  task automatic test_exception_order();
    id_ready = 1;
    next(); req(32'h1c000500, 4'd0);
    next(); req(32'h1c000504, 4'b0001); inst_addr_ok = 0; #1;
    n_checks++; if (if_ready !== 1'b1) begin n_errors++; $display("FAIL ex_ready got %b exp 1", if_ready); end
    next(); #1;
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL ex_blocked got %b exp 0", id_valid); end
    next(); resp(32'hE0000500); #1;
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL ex_blocked2 got %b exp 0", id_valid); end
    next(); #1;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h1c000500 || id_inst !== 32'hE0000500 || id_except_type !== 4'd0) begin
      n_errors++; $display("FAIL ex_a got v=%b pc=%h inst=%h et=%h", id_valid, id_pc, id_inst, id_except_type); end
    next(); #1;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h1c000504 || id_inst !== 32'h0 || id_except_type !== 4'b0001
                    || id_branch !== 1'b1 || id_branch_addr !== 32'h1c000544) begin
      n_errors++; $display("FAIL ex_b got v=%b pc=%h inst=%h et=%h br=%b bra=%h", id_valid, id_pc, id_inst,
        id_except_type, id_branch, id_branch_addr); end
    next(); req(32'h1c000600, 4'b0100); #1;
    n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL ex_empty got %b exp 0", id_valid); end
    next(); #1;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h1c000600 || id_except_type !== 4'b0100) begin
      n_errors++; $display("FAIL ex_head_latency got v=%b pc=%h et=%h", id_valid, id_pc, id_except_type); end
    next(); #1;
  endtask

  task automatic test_rst_mid();
    id_ready = 0;
    next(); req(32'h1c000700, 4'd0);
    next(); flush = 1;
    next(); req(32'h1c000704, 4'b0010);
    next(); req(32'h1c000708, 4'd0);
    next(); req(32'h1c00070c, 4'd0); #1;
    n_checks++; if (if_ready !== 1'b1) begin n_errors++; $display("FAIL rm_third_push got %b exp 1", if_ready); end
    next(); rst = 1; req(32'h1c000710, 4'd0); #1;
    n_checks++; if (if_ready !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h1c000704) begin
      n_errors++; $display("FAIL rm_pre got rdy=%b v=%b pc=%h exp rdy=0 v=1 pc=1c000704", if_ready, id_valid, id_pc); end
    n_checks++; if (dut.discard_q !== 3'd1 || dut.count_q !== 3'd3) begin
      n_errors++; $display("FAIL rm_pre_state got disc=%0d cnt=%0d exp 1 3", dut.discard_q, dut.count_q); end
    next(); rst = 0; #1;
    n_checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || dut.count_q !== 3'd0 || dut.discard_q !== 3'd0) begin
      n_errors++; $display("FAIL rm_post got v=%b pc=%h cnt=%0d disc=%0d exp all 0", id_valid, id_pc, dut.count_q, dut.discard_q); end
    id_ready = 1;
    next(); req(32'h1c000800, 4'd0);
    next(); resp(32'hF0000800);
    next(); #1;
    n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h1c000800 || id_inst !== 32'hF0000800) begin
      n_errors++; $display("FAIL rm_after got v=%b pc=%h inst=%h exp pc=1c000800 inst=f0000800", id_valid, id_pc, id_inst); end
    next(); #1;
  endtask

  initial begin
    idle();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_pending();
    test_flush_data();
    test_exception_order();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
